// File: rtl/rtl_kernel_1_axi_pkg.sv
//==============================================================================
// Module : rtl_kernel_1_axi_pkg
// Brief  : Shared types and constants for the kernel AXI memory responder.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package rtl_kernel_1_axi_pkg;

    localparam int LP_AXI_LEN_WIDTH = 8;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/rtl_kernel_1_axi_mem_ram.sv
//==============================================================================
// Module : rtl_kernel_1_axi_mem_ram
// Brief  : Simple dual-port RAM, byte-enabled write port A, registered
//          read-first read port B with enable.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module rtl_kernel_1_axi_mem_ram #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_BITS  = 10
) (
    input  logic                      ap_clk,
    input  logic                      areset,
    input  logic [DATA_WIDTH/8-1:0]   i_a_we,
    input  logic [ADDR_BITS-1:0]      i_a_addr,
    input  logic [DATA_WIDTH-1:0]     i_a_wdata,
    input  logic                      i_b_en,
    input  logic [ADDR_BITS-1:0]      i_b_addr,
    output logic [DATA_WIDTH-1:0]     o_b_rdata
);

    localparam int c_NUM_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_BITS];

    always_ff @(posedge ap_clk) begin
        for (int b = 0; b < c_NUM_BYTES; b++) begin
            if (i_a_we[b]) begin
                r_mem[i_a_addr][b*8 +: 8] <= i_a_wdata[b*8 +: 8];
            end
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            o_b_rdata <= '0;
        end else if (i_b_en) begin
            o_b_rdata <= r_mem[i_b_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/rtl_kernel_1_axi_mem_responder.sv
//==============================================================================
// Module : rtl_kernel_1_axi_mem_responder
// Brief  : AXI4 responder memory model serving INCR write/read bursts.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module rtl_kernel_1_axi_mem_responder
    import rtl_kernel_1_axi_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 64,
    parameter int C_S_AXI_DATA_WIDTH = 512,
    parameter int C_MEM_DEPTH_WORDS  = 1024
) (
    input  logic                            ap_clk,
    input  logic                            areset,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [LP_AXI_LEN_WIDTH-1:0]     s_axi_awlen,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [LP_AXI_LEN_WIDTH-1:0]     s_axi_arlen,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                            s_axi_rlast,
    output logic                            wlast_err,
    output logic [31:0]                     stat_wr_bursts,
    output logic [31:0]                     stat_rd_bursts
);

    localparam int c_NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;
    localparam int c_OFF_BITS  = $clog2(c_NUM_BYTES);
    localparam int c_IDX_BITS  = $clog2(C_MEM_DEPTH_WORDS);

    // ---------------- write channel ----------------
    wr_state_t                     r_wr_state, w_wr_next;
    logic [c_IDX_BITS-1:0]         r_wr_idx;
    logic [LP_AXI_LEN_WIDTH-1:0]   r_wr_len, r_wr_beat;
    logic                          r_awready, r_wready, r_bvalid, r_wlast_err;
    logic [31:0]                   r_wr_bursts;
    logic                          w_aw_hs, w_w_hs, w_b_hs;
    logic [c_NUM_BYTES-1:0]        w_ram_we;

    assign w_aw_hs  = s_axi_awvalid & r_awready;
    assign w_w_hs   = s_axi_wvalid & r_wready;
    assign w_b_hs   = s_axi_bready & r_bvalid;
    assign w_ram_we = w_w_hs ? s_axi_wstrb : '0;

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_aw_hs) w_wr_next = W_DATA;
            W_DATA:  if (w_w_hs && (r_wr_beat == r_wr_len)) w_wr_next = W_RESP;
            W_RESP:  if (w_b_hs) w_wr_next = W_IDLE;
            default: w_wr_next = W_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they are 0 in reset.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_wr_state  <= W_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_wlast_err <= 1'b0;
            r_wr_bursts <= '0;
        end else begin
            r_wr_state <= w_wr_next;
            r_awready  <= (w_wr_next == W_IDLE);
            r_wready   <= (w_wr_next == W_DATA);
            r_bvalid   <= (w_wr_next == W_RESP);
            if (w_w_hs && ((r_wr_beat == r_wr_len) != s_axi_wlast)) begin
                r_wlast_err <= 1'b1;
            end
            if (w_b_hs) begin
                r_wr_bursts <= r_wr_bursts + 32'd1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_aw_hs) begin
            r_wr_idx  <= s_axi_awaddr[c_OFF_BITS +: c_IDX_BITS];
            r_wr_len  <= s_axi_awlen;
            r_wr_beat <= '0;
        end else if (w_w_hs) begin
            r_wr_idx  <= r_wr_idx + c_IDX_BITS'(1);
            r_wr_beat <= r_wr_beat + 8'd1;
        end
    end

    // ---------------- read channel ----------------
    rd_state_t                     r_rd_state, w_rd_next;
    logic [c_IDX_BITS-1:0]         r_rd_idx;
    logic [LP_AXI_LEN_WIDTH-1:0]   r_rd_len;
    logic [LP_AXI_LEN_WIDTH:0]     r_rd_issued;
    logic                          r_arready, r_rvalid, r_rlast;
    logic [31:0]                   r_rd_bursts;
    logic                          w_ar_hs, w_r_hs, w_r_load, w_r_done;

    assign w_ar_hs  = s_axi_arvalid & r_arready;
    assign w_r_hs   = r_rvalid & s_axi_rready;
    assign w_r_done = w_r_hs & r_rlast;
    assign w_r_load = (r_rd_state == R_DATA) && (r_rd_issued <= {1'b0, r_rd_len})
                      && (!r_rvalid || s_axi_rready);

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs) w_rd_next = R_DATA;
            R_DATA:  if (w_r_done) w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_rd_state  <= R_IDLE;
            r_arready   <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_rd_bursts <= '0;
        end else begin
            r_rd_state <= w_rd_next;
            r_arready  <= (w_rd_next == R_IDLE);
            if (w_r_load) begin
                r_rvalid <= 1'b1;
                r_rlast  <= (r_rd_issued == {1'b0, r_rd_len});
            end else if (w_r_hs) begin
                r_rvalid <= 1'b0;
                r_rlast  <= 1'b0;
            end
            if (w_r_done) begin
                r_rd_bursts <= r_rd_bursts + 32'd1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_ar_hs) begin
            r_rd_idx    <= s_axi_araddr[c_OFF_BITS +: c_IDX_BITS];
            r_rd_len    <= s_axi_arlen;
            r_rd_issued <= '0;
        end else if (w_r_load) begin
            r_rd_idx    <= r_rd_idx + c_IDX_BITS'(1);
            r_rd_issued <= r_rd_issued + 9'd1;
        end
    end

    // The RAM output register doubles as the R-channel data register.
    rtl_kernel_1_axi_mem_ram #(
        .DATA_WIDTH (C_S_AXI_DATA_WIDTH),
        .ADDR_BITS  (c_IDX_BITS)
    ) u_ram (
        .ap_clk    (ap_clk),
        .areset    (areset),
        .i_a_we    (w_ram_we),
        .i_a_addr  (r_wr_idx),
        .i_a_wdata (s_axi_wdata),
        .i_b_en    (w_r_load),
        .i_b_addr  (r_rd_idx),
        .o_b_rdata (s_axi_rdata)
    );

    // Byte-offset and upper address bits are intentionally ignored.
    logic w_unused_addr;
    assign w_unused_addr = ^{s_axi_awaddr, s_axi_araddr};

    assign s_axi_awready  = r_awready;
    assign s_axi_wready   = r_wready;
    assign s_axi_bvalid   = r_bvalid;
    assign s_axi_arready  = r_arready;
    assign s_axi_rvalid   = r_rvalid;
    assign s_axi_rlast    = r_rlast;
    assign wlast_err      = r_wlast_err;
    assign stat_wr_bursts = r_wr_bursts;
    assign stat_rd_bursts = r_rd_bursts;

endmodule

`default_nettype wire

// File: tb/tb_rtl_kernel_1_axi_mem_responder.sv
//==============================================================================
// Module : tb_rtl_kernel_1_axi_mem_responder
// Brief  : Scoreboard bench for the AXI memory responder.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_rtl_kernel_1_axi_mem_responder;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int NB = DW / 8;
    localparam int DEPTH = 1024;

    logic           ap_clk = 1'b0;
    logic           areset = 1'b1;
    logic           s_axi_awvalid = 0, s_axi_awready;
    logic [AW-1:0]  s_axi_awaddr = '0;
    logic [7:0]     s_axi_awlen = '0;
    logic           s_axi_wvalid = 0, s_axi_wready;
    logic [DW-1:0]  s_axi_wdata = '0;
    logic [NB-1:0]  s_axi_wstrb = '0;
    logic           s_axi_wlast = 0;
    logic           s_axi_bvalid, s_axi_bready = 0;
    logic           s_axi_arvalid = 0, s_axi_arready;
    logic [AW-1:0]  s_axi_araddr = '0;
    logic [7:0]     s_axi_arlen = '0;
    logic           s_axi_rvalid, s_axi_rready = 0;
    logic [DW-1:0]  s_axi_rdata;
    logic           s_axi_rlast;
    logic           wlast_err;
    logic [31:0]    stat_wr_bursts, stat_rd_bursts;

    rtl_kernel_1_axi_mem_responder dut (
        .ap_clk(ap_clk), .areset(areset),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast),
        .wlast_err(wlast_err),
        .stat_wr_bursts(stat_wr_bursts), .stat_rd_bursts(stat_rd_bursts)
    );

    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_wr = 0;
    int exp_rd = 0;

    logic [DW-1:0] mem_model [DEPTH];
    logic [DW-1:0] wd [256];
    logic [NB-1:0] ws [256];
    logic [DW-1:0] exp_data_q [$];
    logic          exp_last_q [$];

    function automatic int widx(input logic [AW-1:0] a);
        return int'((a >> 6) & 64'd1023);
    endfunction

    // Entered and left at a falling edge.
    task automatic wr_burst(input logic [AW-1:0] addr, input int len, input int early);
        int n;
        int base;
        base = widx(addr);
        s_axi_awvalid = 1; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
        n = 0;
        while (!s_axi_awready && n < 50) begin @(negedge ap_clk); n++; end
        if (!s_axi_awready) begin n_bad++; $display("FAIL aw_timeout: awready=%b required 1", s_axi_awready); end
        n_cmp++;
        @(negedge ap_clk);
        s_axi_awvalid = 0;
        n_cmp++;
        if (s_axi_wready !== 1'b1) begin n_bad++; $display("FAIL wready_latency: got %b required 1", s_axi_wready); end
        for (int b = 0; b <= len; b++) begin
            s_axi_wvalid = 1; s_axi_wdata = wd[b]; s_axi_wstrb = ws[b];
            s_axi_wlast = (early >= 0) ? (b == early) : (b == len);
            n = 0;
            while (!s_axi_wready && n < 50) begin @(negedge ap_clk); n++; end
            if (!s_axi_wready) begin n_cmp++; n_bad++; $display("FAIL w_timeout: wready=%b required 1", s_axi_wready); end
            for (int k = 0; k < NB; k++)
                if (ws[b][k]) mem_model[(base + b) % DEPTH][k*8 +: 8] = wd[b][k*8 +: 8];
            @(negedge ap_clk);
        end
        s_axi_wvalid = 0; s_axi_wlast = 0;
        n_cmp++;
        if (s_axi_bvalid !== 1'b1) begin n_bad++; $display("FAIL bvalid_latency: got %b required 1", s_axi_bvalid); end
        n = 0;
        while (!s_axi_bvalid && n < 50) begin @(negedge ap_clk); n++; end
        s_axi_bready = 1;
        @(negedge ap_clk);
        s_axi_bready = 0;
        exp_wr++;
        n_cmp++;
        if (s_axi_bvalid !== 1'b0 || stat_wr_bursts !== 32'(exp_wr)) begin
            n_bad++;
            $display("FAIL b_done: bvalid=%b stat_wr=%0d required 0/%0d", s_axi_bvalid, stat_wr_bursts, exp_wr);
        end
    endtask

    task automatic rd_burst(input logic [AW-1:0] addr, input int len, input bit stall);
        int base, cyc, beats, first_v, first_hs, last_hs;
        bit held, rr;
        logic [DW-1:0] hd;
        logic hl, ed, el_unused;
        logic [DW-1:0] edata;
        base = widx(addr);
        for (int b = 0; b <= len; b++) begin
            exp_data_q.push_back(mem_model[(base + b) % DEPTH]);
            exp_last_q.push_back(b == len);
        end
        s_axi_arvalid = 1; s_axi_araddr = addr; s_axi_arlen = 8'(len);
        cyc = 0;
        while (!s_axi_arready && cyc < 50) begin @(negedge ap_clk); cyc++; end
        @(negedge ap_clk);
        s_axi_arvalid = 0;
        cyc = 0; beats = 0; first_v = -1; first_hs = -1; last_hs = -1; held = 0;
        hd = '0; hl = 0; ed = 0; el_unused = 0;
        while (beats <= len && cyc < 2000) begin
            if (held) begin
                n_cmp++;
                if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== hd || s_axi_rlast !== hl) begin
                    n_bad++;
                    $display("FAIL r_stall_hold: rvalid=%b rlast=%b required 1/%b data_changed=%b",
                             s_axi_rvalid, s_axi_rlast, hl, s_axi_rdata !== hd);
                end
            end
            rr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axi_rready = rr;
            if (s_axi_rvalid === 1'b1 && first_v < 0) first_v = cyc;
            if (s_axi_rvalid === 1'b1 && rr) begin
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                n_cmp++;
                if (exp_data_q.size() == 0) begin
                    n_bad++; $display("FAIL r_unexpected: beat %0d with empty scoreboard", beats);
                end else begin
                    edata = exp_data_q.pop_front();
                    ed = exp_last_q.pop_front();
                    if (s_axi_rdata !== edata || s_axi_rlast !== ed) begin
                        n_bad++;
                        $display("FAIL r_beat%0d: rdata=%h rlast=%b required %h / %b",
                                 beats, s_axi_rdata, s_axi_rlast, edata, ed);
                    end
                end
                beats++;
            end
            held = s_axi_rvalid && !rr; hd = s_axi_rdata; hl = s_axi_rlast;
            @(negedge ap_clk);
            cyc++;
        end
        s_axi_rready = 0;
        exp_rd++;
        n_cmp++;
        if (beats != len + 1) begin n_bad++; $display("FAIL r_timeout: beats=%0d required %0d", beats, len + 1); end
        n_cmp++;
        if (first_v != 1) begin n_bad++; $display("FAIL r_latency: first rvalid at cycle %0d required 1", first_v); end
        if (!stall) begin
            n_cmp++;
            if (last_hs - first_hs != len) begin
                n_bad++; $display("FAIL r_throughput: span=%0d required %0d", last_hs - first_hs, len);
            end
        end
        n_cmp++;
        if (s_axi_rvalid !== 1'b0 || s_axi_rlast !== 1'b0 || stat_rd_bursts !== 32'(exp_rd)) begin
            n_bad++;
            $display("FAIL r_done: rvalid=%b rlast=%b stat_rd=%0d required 0/0/%0d",
                     s_axi_rvalid, s_axi_rlast, stat_rd_bursts, exp_rd);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge ap_clk);
        n_cmp++;
        if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast, wlast_err} !== 7'b0
            || s_axi_rdata !== '0 || stat_wr_bursts !== 32'd0 || stat_rd_bursts !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_state: aw/ar/w/b/rv/rl/err=%b rdata_nz=%b required all 0",
                     {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast, wlast_err},
                     s_axi_rdata !== '0);
        end
        areset = 0;
        @(negedge ap_clk);
        n_cmp++;
        if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
            n_bad++; $display("FAIL idle_ready: awready=%b arready=%b required 1/1", s_axi_awready, s_axi_arready);
        end
    endtask

    task automatic test_single_beat;
        wd[0] = {NB{8'hA5}}; ws[0] = '1;
        wr_burst(64'h40, 0, -1);
        rd_burst(64'h40, 0, 0);
        n_cmp++;
        if (wlast_err !== 1'b0) begin n_bad++; $display("FAIL wlast_err_clean: got %b required 0", wlast_err); end
    endtask

    task automatic test_burst16;
        for (int b = 0; b < 16; b++) begin wd[b] = DW'(b); ws[b] = '1; end
        wr_burst(64'h0, 15, -1);
        rd_burst(64'h0, 15, 0);
    endtask

    task automatic test_partial_strobe;
        wd[0] = {NB{8'hFF}}; ws[0] = '1;
        wr_burst(64'h80, 0, -1);
        wd[0] = '0; ws[0] = NB'(1);
        wr_burst(64'h80, 0, -1);
        n_cmp++;
        if (mem_model[2] !== {{(NB-1){8'hFF}}, 8'h00}) begin
            n_bad++; $display("FAIL strobe_model: got %h", mem_model[2]);
        end
        rd_burst(64'h80, 0, 0);
    endtask

    task automatic test_wrap;
        wd[0] = {16{32'hDEAD_0001}}; wd[1] = {16{32'hBEEF_0002}}; ws[0] = '1; ws[1] = '1;
        wr_burst(64'hFFC0, 1, -1);
        rd_burst(64'hFFC0, 1, 0);
        rd_burst(64'h0, 0, 0);
    endtask

    task automatic test_rready_stall;
        for (int b = 0; b < 8; b++) begin wd[b] = {16{$urandom()}}; ws[b] = '1; end
        wr_burst(64'h1000, 7, -1);
        rd_burst(64'h1000, 7, 1);
    endtask

    task automatic test_wlast_err;
        for (int b = 0; b < 4; b++) begin wd[b] = {16{32'h5A5A_0000 + 32'(b)}}; ws[b] = '1; end
        wr_burst(64'h2000, 3, 2);
        n_cmp++;
        if (wlast_err !== 1'b1) begin n_bad++; $display("FAIL wlast_err_set: got %b required 1", wlast_err); end
        wr_burst(64'h2100, 0, -1);
        n_cmp++;
        if (wlast_err !== 1'b1) begin n_bad++; $display("FAIL wlast_err_sticky: got %b required 1", wlast_err); end
        rd_burst(64'h2000, 3, 0);
    endtask

    task automatic test_reset_mid_read;
        s_axi_arvalid = 1; s_axi_araddr = 64'h0; s_axi_arlen = 8'd7;
        @(negedge ap_clk);
        s_axi_arvalid = 0;
        repeat (2) @(negedge ap_clk);
        n_cmp++;
        if (s_axi_rvalid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_rvalid: got %b required 1", s_axi_rvalid); end
        areset = 1;
        @(negedge ap_clk);
        n_cmp++;
        if (s_axi_rvalid !== 1'b0 || s_axi_rlast !== 1'b0 || s_axi_rdata !== '0 || wlast_err !== 1'b0
            || stat_wr_bursts !== 32'd0 || stat_rd_bursts !== 32'd0) begin
            n_bad++;
            $display("FAIL mid_read_reset: rvalid=%b rlast=%b err=%b wr=%0d rd=%0d required 0/0/0/0/0",
                     s_axi_rvalid, s_axi_rlast, wlast_err, stat_wr_bursts, stat_rd_bursts);
        end
        areset = 0;
        exp_wr = 0; exp_rd = 0;
        repeat (2) @(negedge ap_clk);
        rd_burst(64'h0, 15, 0);
    endtask

    initial begin
        test_reset;
        test_single_beat;
        test_burst16;
        test_partial_strobe;
        test_wrap;
        test_rready_stall;
        test_wlast_err;
        test_reset_mid_read;
        repeat (2) @(negedge ap_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
